// File: rtl/ulpi_link_reg_ctrl.sv
// ULPI link-side PHY register access controller with RX CMD capture.
// Define ULPI_REG_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES.
module ulpi_link_reg_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_DATA_OE,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  output logic       ULPI_STP,
  input  logic       REG_REQ,
  input  logic       REG_WR,
  input  logic [5:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  output logic       REG_BUSY,
  output logic       REG_DONE,
  output logic       REG_ABORT,
  output logic [7:0] REG_RDATA,
  output logic       RXCMD_VALID,
  output logic [7:0] RXCMD
);

  typedef enum logic [2:0] {
    IDLE,
    TXCMD,
    WDATA,
    WSTP,
    RD_TURN,
    RD_DATA,
    RX_TURN,
    RX
  } state_t;

  state_t     state_q, state_d;
  logic       wr_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic       lat;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rxcmd_q, rxcmd_d;
  logic       rxv_q, rxv_d;
  logic       rdgot_q, rdgot_d;
  logic       tmo;
  logic [7:0] out;
  logic       drive;

`ifdef ULPI_REG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Restart on every state change so each wait gets a full budget.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {TXCMD, WDATA, RD_TURN}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    rdata_d = rdata_q;
    rxcmd_d = rxcmd_q;
    rxv_d   = 1'b0;
    rdgot_d = rdgot_q;
    lat     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ULPI_DIR) begin
          state_d = RX_TURN;
        end else if (REG_REQ && !busy_q) begin
          state_d = TXCMD;
          busy_d  = 1'b1;
          lat     = 1'b1;
        end
      end
      TXCMD: begin
        if (ULPI_DIR) begin
          state_d = RX_TURN;
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end else if (ULPI_NXT) begin
          state_d = wr_q ? WDATA : RD_TURN;
        end else if (tmo) begin
          state_d = IDLE;
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      WDATA: begin
        if (ULPI_DIR) begin
          state_d = RX_TURN;
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end else if (ULPI_NXT) begin
          state_d = WSTP;
        end else if (tmo) begin
          state_d = IDLE;
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      WSTP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      RD_TURN: begin
        if (ULPI_DIR) begin
          state_d = RD_DATA;
          rdgot_d = 1'b0;
        end else if (tmo) begin
          state_d = IDLE;
          abort_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      RD_DATA: begin
        if (ULPI_DIR) begin
          if (!rdgot_q) begin
            rdata_d = ULPI_DATA_IN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rdgot_d = 1'b1;
          end
        end else begin
          // PHY gave the bus back before any data byte.
          state_d = IDLE;
          if (!rdgot_q) begin
            abort_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      RX_TURN: begin
        state_d = ULPI_DIR ? RX : IDLE;
      end
      RX: begin
        if (ULPI_DIR) begin
          if (!ULPI_NXT) begin
            rxcmd_d = ULPI_DATA_IN;
            rxv_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= 8'h00;
      rxcmd_q <= 8'h00;
      rxv_q   <= 1'b0;
      rdgot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
      rxcmd_q <= rxcmd_d;
      rxv_q   <= rxv_d;
      rdgot_q <= rdgot_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= 1'b0;
      addr_q  <= 6'h00;
      wdata_q <= 8'h00;
    end else if (lat) begin
      wr_q    <= REG_WR;
      addr_q  <= REG_ADDR;
      wdata_q <= REG_WDATA;
    end
  end

  always_comb begin
    out   = 8'h00;
    drive = 1'b0;
    unique case (state_q)
      TXCMD: begin
        out   = {1'b1, ~wr_q, addr_q};
        drive = 1'b1;
      end
      WDATA: begin
        out   = wdata_q;
        drive = 1'b1;
      end
      WSTP: begin
        drive = 1'b1;
      end
      default: begin
        out   = 8'h00;
        drive = 1'b0;
      end
    endcase
  end

  // DIR gating is combinational so a PHY bus grab never collides.
  assign ULPI_DATA_OE  = drive & ~ULPI_DIR;
  assign ULPI_DATA_OUT = out;
  assign ULPI_STP      = (state_q == WSTP);
  assign REG_BUSY      = busy_q;
  assign REG_DONE      = done_q;
  assign REG_ABORT     = abort_q;
  assign REG_RDATA     = rdata_q;
  assign RXCMD_VALID   = rxv_q;
  assign RXCMD         = rxcmd_q;

endmodule

// File: tb/tb_ulpi_link_reg_ctrl.sv
// Randomized PHY-side bench for ulpi_link_reg_ctrl.
// Scoreboard of expected done/abort/rxcmd events, popped by a monitor.
module tb_ulpi_link_reg_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] ULPI_DATA_IN = 8'h00;
  logic [7:0] ULPI_DATA_OUT;
  logic       ULPI_DATA_OE;
  logic       ULPI_DIR = 1'b0;
  logic       ULPI_NXT = 1'b0;
  logic       ULPI_STP;
  logic       REG_REQ = 1'b0;
  logic       REG_WR = 1'b0;
  logic [5:0] REG_ADDR = 6'h00;
  logic [7:0] REG_WDATA = 8'h00;
  logic       REG_BUSY;
  logic       REG_DONE;
  logic       REG_ABORT;
  logic [7:0] REG_RDATA;
  logic       RXCMD_VALID;
  logic [7:0] RXCMD;

  ulpi_link_reg_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST),
    .ULPI_DATA_IN(ULPI_DATA_IN), .ULPI_DATA_OUT(ULPI_DATA_OUT),
    .ULPI_DATA_OE(ULPI_DATA_OE), .ULPI_DIR(ULPI_DIR),
    .ULPI_NXT(ULPI_NXT), .ULPI_STP(ULPI_STP),
    .REG_REQ(REG_REQ), .REG_WR(REG_WR), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_BUSY(REG_BUSY), .REG_DONE(REG_DONE),
    .REG_ABORT(REG_ABORT), .REG_RDATA(REG_RDATA),
    .RXCMD_VALID(RXCMD_VALID), .RXCMD(RXCMD)
  );

  always #5 CLK = ~CLK;

  localparam int EV_DONE  = 0;
  localparam int EV_ABORT = 1;
  localparam int EV_RX    = 2;

  typedef struct {
    int         k;
    bit         rd;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  ev_t me;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void push(int k, bit rd, logic [7:0] d);
    ev_t e;
    e.k  = k;
    e.rd = rd;
    e.d  = d;
    q.push_back(e);
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (REG_DONE) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          chk("ev_kind_done", EV_DONE, me.k);
          chk("busy_at_done", REG_BUSY, 0);
          if (me.rd) chk("rdata", REG_RDATA, me.d);
        end
      end
      if (REG_ABORT) begin
        if (q.size() == 0) begin
          chk("unexpected_abort", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          chk("ev_kind_abort", EV_ABORT, me.k);
          chk("busy_at_abort", REG_BUSY, 0);
        end
      end
      if (RXCMD_VALID) begin
        if (q.size() == 0) begin
          chk("unexpected_rxcmd", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          chk("ev_kind_rx", EV_RX, me.k);
          chk("rxcmd", RXCMD, me.d);
        end
      end
    end
  end

  task automatic drv(logic dir, logic nxt, logic [7:0] d);
    ULPI_DIR     = dir;
    ULPI_NXT     = nxt;
    ULPI_DATA_IN = d;
    @(negedge CLK);
  endtask

  task automatic nx;
    @(posedge CLK);
    #1;
  endtask

  task automatic req(logic wr, logic [5:0] a, logic [7:0] w);
    REG_REQ = 1'b1;
    REG_WR = wr;
    REG_ADDR = a;
    REG_WDATA = w;
    drv(1'b0, 1'b0, rb());
    chk("busy_before_req", REG_BUSY, 0);
    nx();
    REG_REQ = 1'b0;
    REG_WR = ~wr;
    REG_ADDR = 6'($urandom);
    REG_WDATA = rb();
  endtask

  task automatic do_write(logic [5:0] a, logic [7:0] w, int d1, int d2);
    req(1'b1, a, w);
    for (int i = 0; i < d1; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("wr_cmd_out", ULPI_DATA_OUT, {2'b10, a});
      chk("wr_cmd_oe", ULPI_DATA_OE, 1);
      chk("wr_busy", REG_BUSY, 1);
      nx();
    end
    REG_REQ = 1'b1;
    drv(1'b0, 1'b1, rb());
    chk("wr_cmd_out_nxt", ULPI_DATA_OUT, {2'b10, a});
    nx();
    REG_REQ = 1'b0;
    for (int i = 0; i < d2; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("wr_data_out", ULPI_DATA_OUT, w);
      nx();
    end
    drv(1'b0, 1'b1, rb());
    chk("wr_data_out_nxt", ULPI_DATA_OUT, w);
    chk("wr_data_stp", ULPI_STP, 0);
    nx();
    push(EV_DONE, 1'b0, 8'h00);
    drv(1'b0, 1'b0, rb());
    chk("wstp_out", ULPI_DATA_OUT, 8'h00);
    chk("wstp_stp", ULPI_STP, 1);
    chk("wstp_oe", ULPI_DATA_OE, 1);
    nx();
    drv(1'b0, 1'b0, rb());
    chk("post_wr_stp", ULPI_STP, 0);
    chk("post_wr_oe", ULPI_DATA_OE, 0);
    chk("post_wr_busy", REG_BUSY, 0);
    nx();
  endtask

  task automatic do_read(logic [5:0] a, int d1, int d3, int ex,
                         logic [7:0] rd);
    req(1'b0, a, rb());
    for (int i = 0; i < d1; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("rd_cmd_out", ULPI_DATA_OUT, {2'b11, a});
      chk("rd_cmd_oe", ULPI_DATA_OE, 1);
      nx();
    end
    drv(1'b0, 1'b1, rb());
    chk("rd_cmd_out_nxt", ULPI_DATA_OUT, {2'b11, a});
    nx();
    for (int i = 0; i < d3; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("rd_turn_oe", ULPI_DATA_OE, 0);
      chk("rd_turn_busy", REG_BUSY, 1);
      nx();
    end
    drv(1'b1, 1'b0, rb());
    chk("rd_ta_oe", ULPI_DATA_OE, 0);
    nx();
    push(EV_DONE, 1'b1, rd);
    drv(1'b1, 1'b0, rd);
    nx();
    for (int i = 0; i < ex; i++) begin
      drv(1'b1, 1'($urandom), rb());
      nx();
    end
    drv(1'b0, 1'b0, rb());
    nx();
    drv(1'b0, 1'b0, rb());
    chk("rd_end_busy", REG_BUSY, 0);
    chk("rd_end_rdata", REG_RDATA, rd);
    chk("rd_end_stp", ULPI_STP, 0);
    nx();
  endtask

  // Two ignored cycles: the turnaround, then the RX_TURN cycle.
  task automatic phy_rx(int len, bit ab);
    logic       n;
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      n = (i >= 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      d = rb();
      drv(1'b1, n, d);
      if (i == 0) begin
        chk("dir_oe", ULPI_DATA_OE, 0);
        chk("dir_stp", ULPI_STP, 0);
        if (ab) push(EV_ABORT, 1'b0, 8'h00);
      end
      if (i >= 2 && !n) push(EV_RX, 1'b0, d);
      nx();
    end
    drv(1'b0, 1'b0, rb());
    nx();
    drv(1'b0, 1'b0, rb());
    chk("rx_end_busy", REG_BUSY, 0);
    chk("rx_end_stp", ULPI_STP, 0);
    nx();
  endtask

  task automatic do_abort(bit in_wd, int k, int len);
    logic [5:0] a;
    logic [7:0] w;
    a = 6'($urandom);
    w = rb();
    req(in_wd ? 1'b1 : 1'($urandom), a, w);
    if (in_wd) begin
      drv(1'b0, 1'b1, rb());
      nx();
    end
    for (int i = 0; i < k; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("ab_pre_oe", ULPI_DATA_OE, 1);
      if (in_wd) chk("ab_pre_wd", ULPI_DATA_OUT, w);
      nx();
    end
    phy_rx(len, 1'b1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_out"}, ULPI_DATA_OUT, 8'h00);
    chk({tag, "_oe"}, ULPI_DATA_OE, 0);
    chk({tag, "_stp"}, ULPI_STP, 0);
    chk({tag, "_busy"}, REG_BUSY, 0);
    chk({tag, "_done"}, REG_DONE, 0);
    chk({tag, "_abort"}, REG_ABORT, 0);
    chk({tag, "_rdata"}, REG_RDATA, 8'h00);
    chk({tag, "_rxv"}, RXCMD_VALID, 0);
    chk({tag, "_rxcmd"}, RXCMD, 8'h00);
  endtask

  initial begin
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_vals("rst");
    @(posedge CLK);
    #1 RST = 1'b0;

    do_write(6'h0A, 8'h55, 1, 0);
    do_read(6'h0A, 0, 0, 1, 8'h04);

    drv(1'b1, 1'b0, rb());
    nx();
    drv(1'b1, 1'b0, rb());
    nx();
    push(EV_RX, 1'b0, 8'h01);
    drv(1'b1, 1'b0, 8'h01);
    nx();
    push(EV_RX, 1'b0, 8'h5A);
    drv(1'b1, 1'b0, 8'h5A);
    nx();
    drv(1'b0, 1'b0, rb());
    nx();
    drv(1'b0, 1'b0, rb());
    chk("rxcmd_hold", RXCMD, 8'h5A);
    nx();

    do_abort(1'b0, 0, 3);
    do_abort(1'b1, 2, 4);

`ifdef ULPI_REG_TIMEOUT_EN
    req(1'b1, 6'h15, 8'hC3);
    for (int i = 0; i < 64; i++) begin
      drv(1'b0, 1'b0, rb());
      chk("tmo_wait_oe", ULPI_DATA_OE, 1);
      nx();
    end
    push(EV_ABORT, 1'b0, 8'h00);
    drv(1'b0, 1'b0, rb());
    chk("tmo_oe", ULPI_DATA_OE, 0);
    chk("tmo_busy", REG_BUSY, 0);
    nx();
`else
    do_write(6'h15, 8'hC3, 100, 3);
`endif

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(6'($urandom), rb(), $urandom_range(0, 3),
                    $urandom_range(0, 3));
        1: do_read(6'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2), rb());
        2: phy_rx($urandom_range(2, 7), 1'b0);
        default: do_abort(1'($urandom), $urandom_range(0, 3),
                          $urandom_range(2, 5));
      endcase
    end

    req(1'b1, 6'h21, 8'h99);
    drv(1'b0, 1'b1, rb());
    nx();
    drv(1'b0, 1'b0, rb());
    chk("pre_rst_wd_oe", ULPI_DATA_OE, 1);
    #1 RST = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1'b0, 1'b1, rb());
      chk("post_rst_busy", REG_BUSY, 0);
      chk("post_rst_stp", ULPI_STP, 0);
      nx();
    end
    drv(1'b0, 1'b0, rb());
    nx();

    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ulpi_link_reg_ctrl.md
ULPI_LINK_REG_CTRL -- requirements
Module: ulpi_link_reg_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 64, meaning the number of cycles to wait for NXT before abandoning a register access.
REQ-002 SHALL have port CLK, input, 1 bit: the 60 MHz ULPI clock from the PHY; it is the only clock.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port ULPI_DATA_IN, input, 8 bits: the ULPI data bus as sampled from the PHY.
REQ-005 SHALL have port ULPI_DATA_OUT, output, 8 bits: the link drive value for the ULPI data bus.
REQ-006 SHALL have port ULPI_DATA_OE, output, 1 bit: drive enable for ULPI_DATA_OUT.
REQ-007 SHALL have ports ULPI_DIR and ULPI_NXT, input, 1 bit each: the PHY bus-direction and throttle signals.
REQ-008 SHALL have port ULPI_STP, output, 1 bit: the link stop signal.
REQ-009 SHALL have port REG_REQ, input, 1 bit: single-cycle access request.
REQ-010 SHALL have ports REG_WR (1 bit), REG_ADDR (6 bits) and REG_WDATA (8 bits), all inputs: access type (1 = write), PHY register address, and write data.
REQ-011 SHALL have port REG_BUSY, output, 1 bit: high while an access is in progress.
REQ-012 SHALL have ports REG_DONE and REG_ABORT, output, 1 bit each: one-cycle completion and abort pulses.
REQ-013 SHALL have port REG_RDATA, output, 8 bits: read data, valid when REG_DONE pulses for a read.
REQ-014 SHALL have port RXCMD_VALID, output, 1 bit, and port RXCMD, output, 8 bits: a one-cycle strobe and the latest RX CMD byte.

Function
REQ-015 The FSM SHALL use the states IDLE, TXCMD, WDATA, WSTP, RD_TURN, RD_DATA, RX_TURN and RX.
REQ-016 In IDLE with ULPI_DIR low, REG_REQ SHALL latch REG_WR, REG_ADDR and REG_WDATA, set REG_BUSY, and move to TXCMD; REG_REQ while REG_BUSY is high SHALL be ignored.
REQ-017 TXCMD SHALL drive {2'b10,addr} for a write or {2'b11,addr} for a read, with OE high, held until NXT is sampled high.
REQ-018 On write, after NXT in TXCMD, WDATA SHALL drive the write data until NXT is sampled high, then WSTP SHALL drive 8'h00 with ULPI_STP high for exactly one cycle, pulse REG_DONE, and return to IDLE.
REQ-019 On read, after NXT in TXCMD, the block SHALL release the bus (OE low) and enter RD_TURN; the cycle in which DIR is first sampled high SHALL be the turnaround cycle, whose data SHALL be ignored.
REQ-020 In RD_DATA, ULPI_DATA_IN SHALL be captured into REG_RDATA with REG_DONE pulsed in the same cycle; the block SHALL then wait for DIR low (one turnaround cycle) before IDLE.
REQ-021 ULPI_DATA_OE SHALL be gated combinationally with ~ULPI_DIR, so the link never drives in a cycle in which DIR is high.
REQ-022 If DIR rises in TXCMD or WDATA, the access SHALL be aborted: REG_ABORT pulses for one cycle, STP is not asserted, and the state becomes RX_TURN; the request is not retried.
REQ-023 In IDLE, DIR rising SHALL move the FSM to RX_TURN (turnaround, data ignored), then to RX.
REQ-024 In RX, each cycle with DIR high and NXT low SHALL load RXCMD and pulse RXCMD_VALID; cycles with NXT high (packet data) SHALL be ignored.
REQ-025 When DIR falls in RX, the state SHALL return to IDLE after one turnaround cycle.
REQ-026 ULPI_STP SHALL be high only in WSTP.

Reset
REQ-027 While RST is high, the state SHALL be IDLE; ULPI_DATA_OUT, RXCMD and REG_RDATA SHALL be 8'h00; ULPI_DATA_OE, ULPI_STP, REG_BUSY, REG_DONE, REG_ABORT and RXCMD_VALID SHALL be 0.
REQ-028 Reset asserted mid-access SHALL drop the access with no REG_DONE or REG_ABORT pulse.

Configuration
REQ-029 With macro ULPI_REG_TIMEOUT_EN defined, a counter SHALL clear on each entry to TXCMD, WDATA or RD_TURN; if TIMEOUT_CYCLES elapse without the awaited NXT or DIR, the block SHALL release the bus, pulse REG_ABORT, and return to IDLE.
REQ-030 Without ULPI_REG_TIMEOUT_EN, no timeout counter SHALL exist, and the block SHALL wait indefinitely.

Verification
REQ-031 Write 0x0A/0x55 with NXT high on the 2nd and 3rd cycles SHALL produce OUT 0x8A, then 0x55, then 0x00 with STP high; REG_DONE SHALL pulse once.
REQ-032 Read 0x0A: after NXT, DIR high for 3 cycles with data 0x04 after turnaround SHALL yield REG_RDATA=0x04 and REG_DONE=1 for one cycle.
REQ-033 DIR high in IDLE, then 0x01 and 0x5A on consecutive cycles with NXT low, SHALL produce two RXCMD_VALID pulses with RXCMD=0x01 and then 0x5A.
REQ-034 DIR rising during TXCMD SHALL cause OE low in the same cycle, a REG_ABORT pulse, and no STP.
REQ-035 With ULPI_REG_TIMEOUT_EN, a write with NXT held low SHALL produce REG_ABORT after 64 cycles and REG_BUSY=0.
REQ-036 RST pulsed during WDATA SHALL produce outputs at reset values at once, with no REG_DONE pulse afterward.
